// File: rtl/decoder_pkg.sv
// Shared types for the one-hot scan decoder: operating mode and FSM state encodings.
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } scan_state_t;

  // Width of a counter running 0..dwell-1, never narrower than one bit.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/decoder_scan_n_next_enabled.sv
// Combinational circular priority search: first enabled channel strictly after idx,
// wrapping round so that idx itself is the last candidate.
module next_enabled_n
  import decoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int M = $clog2(N)
) (
  input  logic [M-1:0] idx,
  input  logic [N-1:0] mask,
  output logic [M-1:0] next_idx,
  output logic         found,
  output logic         wrap
);

  localparam logic [M:0] N_W = (M+1)'(N);

  logic [M-1:0] cand [N];
  logic [N-1:0] hit;

  // Candidate gi is the channel at circular offset gi+1 from idx.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    localparam logic [M:0] OFS = (M+1)'(gi + 1);
    logic [M:0] sum;
    assign sum       = {1'b0, idx} + OFS;
    assign cand[gi]  = (sum >= N_W) ? M'(sum - N_W) : sum[M-1:0];
    assign hit[gi]   = mask[cand[gi]];
  end

  always_comb begin
    next_idx = idx;
    found    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        next_idx = cand[k];
        found    = 1'b1;
      end
    end
  end

  assign wrap = found && (next_idx <= idx);

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with direct-select and masked auto-scan modes.
// Define DECODER_SCAN_BLANK_EN to insert one blank (Y=0) cycle at every scan advance.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DWELL = 4,
  localparam int M     = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         MODE,
  input  logic [M-1:0] SEL,
  input  logic         LOAD,
  input  logic [N-1:0] MASK,
  output logic [N-1:0] Y,
  output logic [M-1:0] IDX,
  output logic         WRAP
);

  localparam int            CW       = cnt_width(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  scan_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [M-1:0]  idx_reg,   idx_next;
  logic [N-1:0]  y_reg,     y_next;
  logic          wrap_reg,  wrap_next;
`ifdef DECODER_SCAN_BLANK_EN
  logic          pend_reg,  pend_next;
`endif

  logic [M-1:0]  nxt_idx;
  logic          nxt_found;
  logic          nxt_wrap;
  logic          sel_valid;
  logic          dwell_done;
  mode_t         mode;

  assign mode       = mode_t'(MODE);
  assign sel_valid  = {1'b0, SEL} < (M+1)'(N);
  assign dwell_done = (cnt_reg == CNT_LAST);

  next_enabled_n #(.N(N)) u_next (
    .idx      (idx_reg),
    .mask     (MASK),
    .next_idx (nxt_idx),
    .found    (nxt_found),
    .wrap     (nxt_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      y_reg     <= '0;
      wrap_reg  <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      pend_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      y_reg     <= y_next;
      wrap_reg  <= wrap_next;
`ifdef DECODER_SCAN_BLANK_EN
      pend_reg  <= pend_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!EN) begin
      state_next = ST_IDLE;
    end else if (mode == MODE_DIRECT) begin
      state_next = ST_DIRECT;
    end else begin
      state_next = ST_SCAN;
`ifdef DECODER_SCAN_BLANK_EN
      // An empty mask has nothing to advance to, so no blank is inserted.
      if (state_reg == ST_SCAN && dwell_done && nxt_found) state_next = ST_BLANK;
`endif
    end
  end

  always_comb begin
    cnt_next  = '0;
    idx_next  = idx_reg;
    y_next    = '0;
    wrap_next = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    pend_next = pend_reg;
`endif
    case (state_next)
      ST_DIRECT: begin
        if (LOAD && sel_valid) idx_next = SEL;
        y_next = ONE << idx_next;
      end
      ST_SCAN: begin
        if (state_reg == ST_SCAN) begin
          if (dwell_done) begin
            if (nxt_found) idx_next = nxt_idx;
            wrap_next = nxt_wrap;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
`ifdef DECODER_SCAN_BLANK_EN
        else if (state_reg == ST_BLANK) begin
          wrap_next = pend_reg;
        end
`endif
        // Entry from idle/direct starts a fresh dwell on the current index.
        y_next = (ONE << idx_next) & MASK;
      end
`ifdef DECODER_SCAN_BLANK_EN
      ST_BLANK: begin
        idx_next  = nxt_idx;
        pend_next = nxt_wrap;
      end
`endif
      default: ;
    endcase
  end

  assign Y    = y_reg;
  assign IDX  = idx_reg;
  assign WRAP = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n: behavioural model plus directed and random stimulus.
// Honours DECODER_SCAN_BLANK_EN when the design is built with the blank cycle.
module tb_decoder_scan_n;

  localparam int N     = 8;
  localparam int DWELL = 4;
`ifdef DECODER_SCAN_BLANK_EN
  localparam int P     = DWELL + 1;
  localparam bit BLANK = 1'b1;
`else
  localparam int P     = DWELL;
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, load;
  logic [2:0] sel;
  logic [7:0] mask;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  logic       en6, mode6, load6;
  logic [2:0] sel6;
  logic [5:0] mask6, y6;
  logic [2:0] idx6;
  logic       wrap6;

  decoder_scan_n #(.N(8), .DWELL(4)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .MODE(mode), .SEL(sel), .LOAD(load),
    .MASK(mask), .Y(y), .IDX(idx), .WRAP(wrap)
  );

  decoder_scan_n #(.N(6), .DWELL(2)) dut6 (
    .CLK(clk), .RESET(rst), .EN(en6), .MODE(mode6), .SEL(sel6), .LOAD(load6),
    .MASK(mask6), .Y(y6), .IDX(idx6), .WRAP(wrap6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: shown channel, cycles spent on it, and whether scanning/blanking.
  int         m_idx   = 0;
  int         m_age   = 0;
  logic [7:0] m_y     = '0;
  bit         m_wrap  = 1'b0;
  bit         m_scan  = 1'b0;
  bit         m_blank = 1'b0;
  bit         m_pend  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_step(input logic r, input logic e, input logic mo,
                                     input logic l, input logic [2:0] s, input logic [7:0] mk);
    int nx;
    bit fnd;
    if (r) begin
      m_idx = 0; m_y = '0; m_wrap = 0; m_age = 0; m_scan = 0; m_blank = 0; m_pend = 0;
    end else if (!e) begin
      m_y = '0; m_wrap = 0; m_age = 0; m_scan = 0; m_blank = 0;
    end else if (!mo) begin
      if (l && int'(s) < N) m_idx = int'(s);
      m_y = 8'(1 << m_idx); m_wrap = 0; m_age = 0; m_scan = 0; m_blank = 0;
    end else begin
      m_wrap = 0;
      if (!m_scan) begin
        m_scan = 1; m_age = 0;
      end else if (m_blank) begin
        m_blank = 0; m_age = 0; m_wrap = m_pend;
      end else if (m_age < DWELL - 1) begin
        m_age++;
      end else begin
        m_age = 0; fnd = 0; nx = m_idx;
        for (int k = 1; k <= N; k++) begin
          if (!fnd && mk[(m_idx + k) % N]) begin
            fnd = 1; nx = (m_idx + k) % N;
          end
        end
        if (fnd) begin
          if (BLANK) begin
            m_blank = 1; m_pend = (nx <= m_idx);
          end else begin
            m_wrap = (nx <= m_idx);
          end
          m_idx = nx;
        end
      end
      m_y = m_blank ? 8'h00 : (8'(1 << m_idx) & mk);
    end
  endfunction

  // One clock: capture inputs, advance the model at the edge, compare 1 ns later.
  task automatic tick();
    logic r, e, mo, l;
    logic [2:0] s;
    logic [7:0] mk;
    r = rst; e = en; mo = mode; l = load; s = sel; mk = mask;
    @(posedge clk);
    model_step(r, e, mo, l, s, mk);
    #1;
    check("y", 32'(y), 32'(m_y));
    check("idx", 32'(idx), 32'(m_idx));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("onehot", 32'($countones(y) <= 1), 32'd1);
  endtask

  initial begin
    int wraps;
    int nz;
    bit seen;

    rst = 1; en = 1; mode = 1; load = 0; sel = 0; mask = 8'hFF;
    en6 = 1; mode6 = 0; load6 = 1; sel6 = 3'd4; mask6 = 6'h3F;

    $display("txn reset: 2 cycles with EN=1 MODE=1");
    tick(); tick();
    check("rst_y", 32'(y), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);

    $display("txn full-mask scan, period %0d; direct loads on N=6 instance", 8 * P);
    rst = 0;
    for (int k = 1; k <= 8 * P + 2; k++) begin
      tick();
      if (k == 1)         check("scan_first", 32'(y), 32'h01);
      if (k == P + 1)     check("scan_ch1", 32'(y), 32'h02);
`ifdef DECODER_SCAN_BLANK_EN
      if (k == DWELL + 1) check("blank_gap", 32'(y), 32'h00);
`endif
      if (k == 7 * P + 1) check("scan_ch7", 32'(y), 32'h80);
      if (k == 8 * P)     check("scan_prewrap", 32'(wrap), 32'h0);
      if (k == 8 * P + 1) begin
        check("scan_wrap_y", 32'(y), 32'h01);
        check("scan_wrap", 32'(wrap), 32'h1);
      end
      if (k == 8 * P + 2) check("scan_wrap_once", 32'(wrap), 32'h0);
      case (k)
        1: begin
          check("d6_load4_y", 32'(y6), 32'h10);
          check("d6_load4_idx", 32'(idx6), 32'd4);
          sel6 = 3'd6;
        end
        2: begin
          check("d6_sel6_y", 32'(y6), 32'h10);
          check("d6_sel6_idx", 32'(idx6), 32'd4);
          sel6 = 3'd7;
        end
        3: begin
          check("d6_sel7_y", 32'(y6), 32'h10);
          load6 = 0; sel6 = 3'd1;
        end
        4: begin
          check("d6_hold_idx", 32'(idx6), 32'd4);
          load6 = 1; sel6 = 3'd5;
        end
        5: begin
          check("d6_load5_y", 32'(y6), 32'h20);
          check("d6_wrap", 32'(wrap6), 32'h0);
          load6 = 0;
        end
        default: ;
      endcase
    end

    $display("txn sparse mask 0xA4 from IDX=2");
    mode = 0; load = 1; sel = 3'd2;
    tick();
    check("load2_idx", 32'(idx), 32'd2);
    load = 0; mode = 1; mask = 8'hA4; wraps = 0;
    for (int j = 1; j <= 3 * P + 1; j++) begin
      tick();
      wraps += int'(wrap);
      if (j == 1) check("sparse_2", 32'(y), 32'h04);
      if (j == P + 1) begin
        check("sparse_5_idx", 32'(idx), 32'd5);
        check("sparse_5_y", 32'(y), 32'h20);
      end
      if (j == 2 * P + 1) check("sparse_7_y", 32'(y), 32'h80);
      if (j == 3 * P + 1) begin
        check("sparse_ret_idx", 32'(idx), 32'd2);
        check("sparse_ret_wrap", 32'(wrap), 32'h1);
      end
    end
    check("sparse_wraps", 32'(wraps), 32'd1);

    $display("txn empty mask, then MASK=0x10 from IDX=0");
    mask = 8'h00; nz = 0;
    for (int t = 0; t < 3 * P; t++) begin
      tick();
      if (y != 0 || wrap) nz++;
    end
    check("empty_quiet", 32'(nz), 32'd0);
    mode = 0; load = 1; sel = 3'd0;
    tick();
    load = 0; mode = 1;
    tick(); tick();
    mask = 8'h10; seen = 0;
    for (int t = 0; t < 2 * P + 2 && !seen; t++) begin
      tick();
      if (y != 0) seen = 1;
    end
    check("empty_appear", 32'(seen), 32'd1);
    check("empty_new_y", 32'(y), 32'h10);
    check("empty_new_idx", 32'(idx), 32'd4);
    check("empty_new_wrap", 32'(wrap), 32'h0);

    $display("txn enable drop at IDX=3");
    mask = 8'hFF; mode = 0; load = 1; sel = 3'd3;
    tick();
    load = 0; mode = 1;
    tick(); tick();
    en = 0;
    tick();
    check("endrop_y", 32'(y), 32'h0);
    check("endrop_idx", 32'(idx), 32'd3);
    en = 1;
    for (int t = 1; t <= DWELL + 1; t++) begin
      tick();
      if (t <= DWELL) check("enret_dwell", 32'(y), 32'h08);
      else            check("enret_adv", 32'(y != 8'h08), 32'd1);
    end

    $display("txn random: 3000 cycles");
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      load = ($urandom_range(0, 3) == 0);
      sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 8'($urandom);
          1:       mask = 8'(1 << $urandom_range(0, 7));
          2:       mask = 8'h00;
          default: mask = 8'hFF;
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
